sdr_app_arb: RTL and testbench

- Arbitrates NUM_REQ application masters onto the single app_req port of the SDRAM controller.
- Grants one master at a time and holds the grant for the whole burst.
- Steers write-data requests and read-data completions back to the granted master.
- Sits between the system-side masters and the controller application interface.

---
 rtl/sdr_arb_pkg.sv | 27 ++
 rtl/sdr_rr_arb.sv | 53 +++++
 rtl/sdr_app_arb.sv | 223 ++++++++++++++++++++++
 tb/tb_sdr_app_arb.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdr_arb_pkg
// Shared types and default widths for the SDRAM application-port arbiter.
// The width defaults mirror the controller's application interface
// (26-bit address, 9-bit burst length, 32-bit data, 4 byte enables).
// -----------------------------------------------------------------------------
package sdr_arb_pkg;

    localparam int NUM_REQ_DEF = 2;
    localparam int APP_AW_DEF  = 26;
    localparam int APP_RW_DEF  = 9;
    localparam int APP_DW_DEF  = 32;
    localparam int APP_BW_DEF  = APP_DW_DEF / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_e;

    // Successor of a requester index, wrapping n-1 -> 0.
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sdr_rr_arb.sv
// -----------------------------------------------------------------------------
// sdr_rr_arb
// Purely combinational rotating-priority picker. Searches the request vector
// starting at ptr and moving upward, wrapping NUM_REQ-1 -> 0; the first set
// bit wins. Driving ptr with a constant 0 turns it into a fixed-priority
// (lowest index wins) picker.
//
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   IW       index with highest priority this cycle
//   gnt      out  NUM_REQ  one-hot grant (all zero when no request)
//   gnt_idx  out  IW       binary index of the granted requester
//   gnt_vld  out  1        at least one request present
// -----------------------------------------------------------------------------
module sdr_rr_arb
    import sdr_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_vld
);

    int            idx;
    logic [IW-1:0] idx_b;

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        idx_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_b = IW'(idx);
            if (!gnt_vld && req[idx_b]) begin
                gnt[idx_b] = 1'b1;
                gnt_idx    = idx_b;
                gnt_vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdr_app_arb.sv
// -----------------------------------------------------------------------------
// sdr_app_arb
// Arbitrates NUM_REQ application masters onto the single app_req port of the
// SDRAM controller. One master owns the port from grant until the last data
// beat of its burst; write-data handshakes and read completions are steered
// back to that owner only.
//
// Configuration macro:
//   SDR_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                       no rotating pointer register
//                          undefined -> round-robin (default)
//
// Ports:
//   sdram_clk, reset                  clock; synchronous active-high reset
//   m_req/_addr/_len/_wr_n/_wrap      per-master request, packed, master 0 LSBs
//   m_wr_data, m_wr_en_n              per-master write data / byte enables
//   m_req_ack, m_wr_next              handshakes back to the owner
//   m_rd_data                         read data broadcast to all masters
//   m_rd_valid, m_last_rd, m_last_wr  completions back to the owner
//   app_*  (out)                      request and write data to controller
//   app_*  (in)                       handshakes and read data from controller
//   busy                              a grant is held (state != IDLE)
// -----------------------------------------------------------------------------
module sdr_app_arb
    import sdr_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int APP_AW  = APP_AW_DEF,
    parameter int APP_RW  = APP_RW_DEF,
    parameter int APP_DW  = APP_DW_DEF,
    parameter int APP_BW  = APP_BW_DEF
) (
    input  logic                      sdram_clk,
    input  logic                      reset,
    // master side
    input  logic [NUM_REQ-1:0]        m_req,
    input  logic [NUM_REQ*APP_AW-1:0] m_req_addr,
    input  logic [NUM_REQ*APP_RW-1:0] m_req_len,
    input  logic [NUM_REQ-1:0]        m_req_wr_n,
    input  logic [NUM_REQ-1:0]        m_req_wrap,
    input  logic [NUM_REQ*APP_DW-1:0] m_wr_data,
    input  logic [NUM_REQ*APP_BW-1:0] m_wr_en_n,
    output logic [NUM_REQ-1:0]        m_req_ack,
    output logic [NUM_REQ-1:0]        m_wr_next,
    output logic [APP_DW-1:0]         m_rd_data,
    output logic [NUM_REQ-1:0]        m_rd_valid,
    output logic [NUM_REQ-1:0]        m_last_rd,
    output logic [NUM_REQ-1:0]        m_last_wr,
    // controller side
    output logic                      app_req,
    output logic [APP_AW-1:0]         app_req_addr,
    output logic [APP_RW-1:0]         app_req_len,
    output logic                      app_req_wr_n,
    output logic                      app_req_wrap,
    output logic [APP_DW-1:0]         app_wr_data,
    output logic [APP_BW-1:0]         app_wr_en_n,
    input  logic                      app_req_ack,
    input  logic                      app_wr_next_req,
    input  logic [APP_DW-1:0]         app_rd_data,
    input  logic                      app_rd_valid,
    input  logic                      app_last_rd,
    input  logic                      app_last_wr,
    output logic                      busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [APP_AW-1:0]   addr_q,  addr_d;
    logic [APP_RW-1:0]   len_q,   len_d;
    logic                wr_n_q,  wr_n_d;
    logic                wrap_q,  wrap_d;

    logic [IW-1:0]       arb_ptr;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_vld;
    logic                wr_phase;
    logic                rd_phase;

`ifdef SDR_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [IW-1:0]       ptr_q, ptr_d;
    assign arb_ptr = ptr_q;
`endif

    sdr_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .req     (m_req),
        .ptr     (arb_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge sdram_clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wr_n_q  <= 1'b1;
            wrap_q  <= 1'b0;
`ifndef SDR_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wr_n_q  <= wr_n_d;
            wrap_q  <= wrap_d;
`ifndef SDR_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wr_n_d  = wr_n_q;
        wrap_d  = wrap_q;
`ifndef SDR_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // Request fields are captured at grant time so app_req_* stay
                // stable for the whole REQ phase.
                if (arb_vld) begin
                    state_d = REQ;
                    owner_d = arb_idx;
                    addr_d  = m_req_addr[arb_idx*APP_AW +: APP_AW];
                    len_d   = m_req_len[arb_idx*APP_RW +: APP_RW];
                    wr_n_d  = m_req_wr_n[arb_idx];
                    wrap_d  = m_req_wrap[arb_idx];
`ifndef SDR_ARB_FIXED_PRIO_EN
                    ptr_d   = IW'(next_idx(int'(arb_idx), NUM_REQ));
`endif
                end
            end
            REQ: begin
                // A one-beat burst may finish in the ack cycle itself.
                if (app_req_ack) begin
                    if (!wr_n_q) begin
                        state_d = app_last_wr ? IDLE : WDATA;
                    end else begin
                        state_d = app_last_rd ? IDLE : RDATA;
                    end
                end
            end
            WDATA: begin
                if (app_last_wr) begin
                    state_d = IDLE;
                end
            end
            RDATA: begin
                if (app_last_rd) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Data-phase steering is also open during REQ for the matching direction,
    // so a beat the controller reports alongside app_req_ack still reaches
    // the owner.
    always_comb begin
        wr_phase    = (state_q == WDATA) || ((state_q == REQ) && !wr_n_q);
        rd_phase    = (state_q == RDATA) || ((state_q == REQ) &&  wr_n_q);

        app_req     = (state_q == REQ);
        busy        = (state_q != IDLE);

        m_req_ack   = '0;
        m_wr_next   = '0;
        m_last_wr   = '0;
        m_rd_valid  = '0;
        m_last_rd   = '0;
        app_wr_data = '0;
        app_wr_en_n = '1;

        if (state_q == REQ) begin
            m_req_ack[owner_q] = app_req_ack;
        end
        if (wr_phase) begin
            app_wr_data        = m_wr_data[owner_q*APP_DW +: APP_DW];
            app_wr_en_n        = m_wr_en_n[owner_q*APP_BW +: APP_BW];
            m_wr_next[owner_q] = app_wr_next_req;
            m_last_wr[owner_q] = app_last_wr;
        end
        if (rd_phase) begin
            m_rd_valid[owner_q] = app_rd_valid;
            m_last_rd[owner_q]  = app_last_rd;
        end
    end

    assign app_req_addr = addr_q;
    assign app_req_len  = len_q;
    assign app_req_wr_n = wr_n_q;
    assign app_req_wrap = wrap_q;
    assign m_rd_data    = app_rd_data;

    // The owner must keep m_req high until it sees its acknowledge.
    a_req_held : assert property (
        @(posedge sdram_clk) disable iff (reset)
        (state_q == REQ) |-> m_req[owner_q]
    );

endmodule

// File: tb/tb_sdr_app_arb.sv
// -----------------------------------------------------------------------------
// tb_sdr_app_arb
// Scoreboard bench for sdr_app_arb with two masters. Stimulus pushes the
// expected grant and data beats into queues; monitors pop and compare them
// whenever the DUT presents an acknowledge, write-next or read-valid.
// -----------------------------------------------------------------------------
module tb_sdr_app_arb;
    import sdr_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 26;
    localparam int RW = 9;
    localparam int DW = 32;
    localparam int BW = 4;

    logic            sdram_clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_req;
    logic [N*AW-1:0] m_req_addr;
    logic [N*RW-1:0] m_req_len;
    logic [N-1:0]    m_req_wr_n;
    logic [N-1:0]    m_req_wrap;
    logic [N*DW-1:0] m_wr_data;
    logic [N*BW-1:0] m_wr_en_n;
    logic [N-1:0]    m_req_ack, m_wr_next, m_rd_valid, m_last_rd, m_last_wr;
    logic [DW-1:0]   m_rd_data;
    logic            app_req, app_req_wr_n, app_req_wrap;
    logic [AW-1:0]   app_req_addr;
    logic [RW-1:0]   app_req_len;
    logic [DW-1:0]   app_wr_data;
    logic [BW-1:0]   app_wr_en_n;
    logic            app_req_ack, app_wr_next_req, app_rd_valid, app_last_rd, app_last_wr;
    logic [DW-1:0]   app_rd_data;
    logic            busy;

    always #5 sdram_clk = ~sdram_clk;

    sdr_app_arb #(
        .NUM_REQ (N), .APP_AW (AW), .APP_RW (RW), .APP_DW (DW), .APP_BW (BW)
    ) dut (
        .sdram_clk       (sdram_clk),
        .reset           (reset),
        .m_req           (m_req),
        .m_req_addr      (m_req_addr),
        .m_req_len       (m_req_len),
        .m_req_wr_n      (m_req_wr_n),
        .m_req_wrap      (m_req_wrap),
        .m_wr_data       (m_wr_data),
        .m_wr_en_n       (m_wr_en_n),
        .m_req_ack       (m_req_ack),
        .m_wr_next       (m_wr_next),
        .m_rd_data       (m_rd_data),
        .m_rd_valid      (m_rd_valid),
        .m_last_rd       (m_last_rd),
        .m_last_wr       (m_last_wr),
        .app_req         (app_req),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_wrap    (app_req_wrap),
        .app_wr_data     (app_wr_data),
        .app_wr_en_n     (app_wr_en_n),
        .app_req_ack     (app_req_ack),
        .app_wr_next_req (app_wr_next_req),
        .app_rd_data     (app_rd_data),
        .app_rd_valid    (app_rd_valid),
        .app_last_rd     (app_last_rd),
        .app_last_wr     (app_last_wr),
        .busy            (busy)
    );

    typedef struct {
        logic [N-1:0]  ack;
        logic [AW-1:0] addr;
        logic [RW-1:0] len;
        logic          wr_n;
        logic          wrap;
    } grant_t;

    typedef struct {
        logic [N-1:0]  who;
        logic [DW-1:0] data;
        logic [BW-1:0] en_n;
    } beat_t;

    grant_t gnt_q[$];
    beat_t  wr_q[$];
    beat_t  rd_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_next_cnt[N];
    int rd_valid_cnt[N];
    int last_wr_cnt[N];
    int last_rd_cnt[N];
    int bad_last;
    int req_left[N];
    int exp_order[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event expected none/earlier", name);
    endtask

    // ------------------------------------------------------------ monitors
    always @(negedge sdram_clk) begin : mon
        grant_t g;
        beat_t  b;
        if (app_req && app_req_ack) begin
            if (gnt_q.size() == 0) begin
                fail_now("grant_unexpected");
            end else begin
                g = gnt_q.pop_front();
                check("grant_ack",  m_req_ack,    g.ack);
                check("grant_addr", app_req_addr, g.addr);
                check("grant_len",  app_req_len,  g.len);
                check("grant_wr_n", app_req_wr_n, g.wr_n);
                check("grant_wrap", app_req_wrap, g.wrap);
            end
        end
        if (|m_wr_next) begin
            if (wr_q.size() == 0) begin
                fail_now("wr_next_unexpected");
            end else begin
                b = wr_q.pop_front();
                check("wr_next_who", m_wr_next,   b.who);
                check("wr_data",     app_wr_data, b.data);
                check("wr_en_n",     app_wr_en_n, b.en_n);
            end
        end
        if (|m_rd_valid) begin
            if (rd_q.size() == 0) begin
                fail_now("rd_valid_unexpected");
            end else begin
                b = rd_q.pop_front();
                check("rd_valid_who", m_rd_valid, b.who);
                check("rd_data",      m_rd_data,  b.data);
            end
        end
        for (int i = 0; i < N; i++) begin
            wr_next_cnt[i]  += int'(m_wr_next[i]);
            rd_valid_cnt[i] += int'(m_rd_valid[i]);
            last_wr_cnt[i]  += int'(m_last_wr[i]);
            last_rd_cnt[i]  += int'(m_last_rd[i]);
            if (m_last_rd[i] && !m_rd_valid[i]) bad_last++;
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic clr_cnt();
        for (int i = 0; i < N; i++) begin
            wr_next_cnt[i]  = 0;
            rd_valid_cnt[i] = 0;
            last_wr_cnt[i]  = 0;
            last_rd_cnt[i]  = 0;
        end
        bad_last = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge sdram_clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_master(input int i, input logic [AW-1:0] addr, input logic [RW-1:0] len,
                              input logic wr_n, input logic wrap, input logic [DW-1:0] data,
                              input logic [BW-1:0] en_n, input int count);
        m_req_addr[i*AW +: AW] = addr;
        m_req_len[i*RW +: RW]  = len;
        m_req_wr_n[i]          = wr_n;
        m_req_wrap[i]          = wrap;
        m_wr_data[i*DW +: DW]  = data;
        m_wr_en_n[i*BW +: BW]  = en_n;
        req_left[i]            = count;
        m_req[i]               = 1'b1;
    endtask

    task automatic push_grant(input int m, input logic [AW-1:0] addr, input logic [RW-1:0] len,
                              input logic wr_n, input logic wrap);
        grant_t g;
        g.ack  = N'(1) << m;
        g.addr = addr;
        g.len  = len;
        g.wr_n = wr_n;
        g.wrap = wrap;
        gnt_q.push_back(g);
    endtask

    // Behavioural controller: waits for app_req, acks after ack_dly extra
    // cycles, then plays `beats` data beats. same_last folds a single read
    // beat into the ack cycle; rst_beat >= 0 resets in the middle of a burst.
    task automatic serve(input int exp_m, input int ack_dly, input int beats, input logic is_wr,
                         input logic [DW-1:0] wdata, input logic [BW-1:0] wen_n,
                         input logic same_last, input logic [DW-1:0] rbase, input int rst_beat);
        int    t;
        beat_t b;
        t = 0;
        @(negedge sdram_clk);
        while (!app_req && t < 20) begin
            @(negedge sdram_clk);
            t++;
        end
        if (!app_req) begin
            n_checks++;
            n_fail++;
            $display("FAIL app_req_timeout: got app_req=0 expected 1 within 20 cycles");
            return;
        end
        repeat (ack_dly) @(posedge sdram_clk);
        @(posedge sdram_clk);
        #1 app_req_ack = 1'b1;
        if (same_last) begin
            app_rd_valid = 1'b1;
            app_rd_data  = rbase;
            app_last_rd  = 1'b1;
            b.who  = N'(1) << exp_m;
            b.data = rbase;
            b.en_n = '1;
            rd_q.push_back(b);
        end
        @(posedge sdram_clk);
        #1;
        app_req_ack  = 1'b0;
        app_rd_valid = 1'b0;
        app_last_rd  = 1'b0;
        req_left[exp_m]--;
        if (req_left[exp_m] <= 0) m_req[exp_m] = 1'b0;
        if (!same_last) begin
            for (int k = 0; k < beats; k++) begin
                b.who = N'(1) << exp_m;
                if (is_wr) begin
                    app_wr_next_req = 1'b1;
                    app_last_wr     = (k == beats - 1);
                    b.data = wdata;
                    b.en_n = wen_n;
                    wr_q.push_back(b);
                end else begin
                    app_rd_valid = 1'b1;
                    app_rd_data  = rbase + DW'(k);
                    app_last_rd  = (k == beats - 1);
                    b.data = rbase + DW'(k);
                    b.en_n = '1;
                    rd_q.push_back(b);
                end
                if (k == rst_beat) reset = 1'b1;
                @(posedge sdram_clk);
                #1;
                if (k == rst_beat) begin
                    reset       = 1'b0;
                    m_req       = '0;
                    req_left[exp_m] = 0;
                    break;
                end
            end
        end
        app_wr_next_req = 1'b0;
        app_last_wr     = 1'b0;
        app_rd_valid    = 1'b0;
        app_last_rd     = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        reset = 1'b1;
        m_req = '0; m_req_addr = '0; m_req_len = '0; m_req_wr_n = '1; m_req_wrap = '0;
        m_wr_data = '0; m_wr_en_n = '1;
        app_req_ack = 1'b0; app_wr_next_req = 1'b0; app_rd_data = '0;
        app_rd_valid = 1'b0; app_last_rd = 1'b0; app_last_wr = 1'b0;
        for (int i = 0; i < N; i++) req_left[i] = 0;
        clr_cnt();
        repeat (3) @(posedge sdram_clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge sdram_clk);
        check("rst_app_req",   app_req,      1'b0);
        check("rst_busy",      busy,         1'b0);
        check("rst_wr_n",      app_req_wr_n, 1'b1);
        check("rst_wr_en_n",   app_wr_en_n,  4'hF);
        check("rst_addr",      app_req_addr, 26'h0);
        check("rst_len",       app_req_len,  9'h0);
        check("rst_req_ack",   m_req_ack,    2'b00);

        // M0 write, len 4, addr 0x100
        @(posedge sdram_clk);
        #1 set_master(0, 26'h100, 9'd4, 1'b0, 1'b0, 32'hA5A5_0001, 4'b1010, 1);
        @(negedge sdram_clk);
        check("t1_latency_early", app_req, 1'b0);
        @(negedge sdram_clk);
        check("t1_app_req", app_req, 1'b1);
        check("t1_busy",    busy,    1'b1);
        push_grant(0, 26'h100, 9'd4, 1'b0, 1'b0);
        serve(0, 2, 4, 1'b1, 32'hA5A5_0001, 4'b1010, 1'b0, '0, -1);
        @(negedge sdram_clk);
        check("t1_idle",      busy,           1'b0);
        check("t1_wr_next0",  wr_next_cnt[0], 4);
        check("t1_wr_next1",  wr_next_cnt[1], 0);
        check("t1_last_wr0",  last_wr_cnt[0], 1);
        check("t1_last_wr1",  last_wr_cnt[1], 0);

        // both request together; M0 asks three times, M1 once
        do_reset();
        clr_cnt();
`ifdef SDR_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 1};
`else
        exp_order = '{0, 1, 0, 0};
`endif
        set_master(0, 26'h200, 9'd2, 1'b1, 1'b0, '0, '1, 3);
        set_master(1, 26'h300, 9'd2, 1'b1, 1'b0, '0, '1, 1);
        for (int r = 0; r < 4; r++) begin
            push_grant(exp_order[r], (exp_order[r] == 1) ? 26'h300 : 26'h200, 9'd2, 1'b1, 1'b0);
            serve(exp_order[r], 0, 2, 1'b0, '0, '1, 1'b0, 32'h1000_0000 + DW'(r * 16), -1);
        end
        check("t2_rd_valid0", rd_valid_cnt[0], 6);
        check("t2_rd_valid1", rd_valid_cnt[1], 2);
        check("t2_last_rd0",  last_rd_cnt[0],  3);
        check("t2_last_rd1",  last_rd_cnt[1],  1);

        // M1 read, len 8, wrap
        clr_cnt();
        set_master(1, 26'h3F0, 9'd8, 1'b1, 1'b1, '0, '1, 1);
        push_grant(1, 26'h3F0, 9'd8, 1'b1, 1'b1);
        serve(1, 1, 8, 1'b0, '0, '1, 1'b0, 32'hBEEF_0000, -1);
        @(negedge sdram_clk);
        check("t3_rd_valid1", rd_valid_cnt[1], 8);
        check("t3_rd_valid0", rd_valid_cnt[0], 0);
        check("t3_last_rd1",  last_rd_cnt[1],  1);
        check("t3_last_coin", bad_last,        0);

        // last_rd together with app_req_ack, M1 waiting behind
        clr_cnt();
        set_master(0, 26'h040, 9'd1, 1'b1, 1'b0, '0, '1, 1);
        set_master(1, 26'h050, 9'd1, 1'b1, 1'b0, '0, '1, 1);
        push_grant(0, 26'h040, 9'd1, 1'b1, 1'b0);
        serve(0, 0, 1, 1'b0, '0, '1, 1'b1, 32'hCAFE_0001, -1);
        @(negedge sdram_clk);
        check("t4_req_to_idle", busy,    1'b0);
        @(negedge sdram_clk);
        check("t4_regrant",     app_req, 1'b1);
        push_grant(1, 26'h050, 9'd1, 1'b1, 1'b0);
        serve(1, 0, 1, 1'b0, '0, '1, 1'b0, 32'hCAFE_0002, -1);
        check("t4_rd_valid0", rd_valid_cnt[0], 1);
        check("t4_last_rd0",  last_rd_cnt[0],  1);
        check("t4_rd_valid1", rd_valid_cnt[1], 1);

        // reset during the second write beat
        set_master(0, 26'h400, 9'd4, 1'b0, 1'b0, 32'h1234_5678, 4'b0000, 1);
        push_grant(0, 26'h400, 9'd4, 1'b0, 1'b0);
        serve(0, 0, 4, 1'b1, 32'h1234_5678, 4'b0000, 1'b0, '0, 1);
        @(negedge sdram_clk);
        check("t5_app_req",   app_req,      1'b0);
        check("t5_busy",      busy,         1'b0);
        check("t5_wr_n",      app_req_wr_n, 1'b1);
        check("t5_wr_en_n",   app_wr_en_n,  4'hF);
        check("t5_addr",      app_req_addr, 26'h0);
        check("t5_wr_next",   m_wr_next,    2'b00);
        set_master(0, 26'h500, 9'd1, 1'b1, 1'b0, '0, '1, 1);
        set_master(1, 26'h600, 9'd1, 1'b1, 1'b0, '0, '1, 1);
        push_grant(0, 26'h500, 9'd1, 1'b1, 1'b0);
        serve(0, 0, 1, 1'b0, '0, '1, 1'b0, 32'h5500_0000, -1);
        push_grant(1, 26'h600, 9'd1, 1'b1, 1'b0);
        serve(1, 0, 1, 1'b0, '0, '1, 1'b0, 32'h6600_0000, -1);

        // only M1 requests, three times
        clr_cnt();
        set_master(1, 26'h700, 9'd2, 1'b0, 1'b0, 32'h0F0F_1111, 4'b0011, 3);
        for (int r = 0; r < 3; r++) begin
            push_grant(1, 26'h700, 9'd2, 1'b0, 1'b0);
            serve(1, 0, 2, 1'b1, 32'h0F0F_1111, 4'b0011, 1'b0, '0, -1);
        end
        @(negedge sdram_clk);
        check("t6_wr_next1", wr_next_cnt[1], 6);
        check("t6_wr_next0", wr_next_cnt[0], 0);
        check("t6_last_wr1", last_wr_cnt[1], 3);

        repeat (2) @(negedge sdram_clk);
        check("end_grants_left", gnt_q.size(), 0);
        check("end_wr_left",     wr_q.size(),  0);
        check("end_rd_left",     rd_q.size(),  0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
